// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU
// operation encodings, FSM state encoding and the packed control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_control_if #(parameter int STATE_W = 4);

    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               pc_en;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               iord;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         aluop;
    logic [1:0]         pcsrc;
    logic               regdst;
    logic               memtoreg;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
               aluop, pcsrc, regdst, memtoreg, illegal_op, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
               aluop, pcsrc, regdst, memtoreg, illegal_op, state_o
    );

endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word decoder. Moore decode except for the
// mem_ready qualification in FETCH, zero in BEQEX and the opcode check in DECODE.
module mc_output_decode
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ok,
    output ctrl_t              ctrl
);

    // Per-state control word; unencoded states fall through to all-zero.
    always_comb begin
        ctrl = '0;
        case (state)
            STATE_W'(S_FETCH): begin
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = mem_ok;
                ctrl.pc_en   = mem_ok;
            end
            STATE_W'(S_DECODE): begin
                ctrl.alusrcb    = 2'b11;
                ctrl.aluop      = ALUOP_ADD;
                ctrl.illegal_op = !op_supported(op);
            end
            STATE_W'(S_MEMADR): begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
            end
            STATE_W'(S_MEMRD): begin
                ctrl.iord = 1'b1;
            end
            STATE_W'(S_MEMWB): begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            STATE_W'(S_RTYPEEX): begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            STATE_W'(S_RTYPEWB): begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            STATE_W'(S_BEQEX): begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.pc_en   = zero;
            end
            STATE_W'(S_ADDIEX): begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
            end
            STATE_W'(S_ADDIWB): begin
                ctrl.regwrite = 1'b1;
            end
            STATE_W'(S_JEX): begin
                ctrl.pcsrc = 2'b10;
                ctrl.pc_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register and
// next-state logic here, output decode in mc_output_decode.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int STATE_W       = 4,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               mem_ok;
    ctrl_t              ctrl;
    ctrl_t              ctrl_out;

    assign mem_ok = USE_MEM_READY ? bus.mem_ready : 1'b1;

    mc_output_decode #(.STATE_W(STATE_W)) u_decode (
        .state  (state_q),
        .op     (bus.op),
        .zero   (bus.zero),
        .mem_ok (mem_ok),
        .ctrl   (ctrl)
    );

    // Next-state selection; anything not explicitly handled returns to FETCH.
    always_comb begin
        state_d = STATE_W'(S_FETCH);
        case (state_q)
            STATE_W'(S_FETCH):   state_d = mem_ok ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
                    OP_RTYPE:     state_d = STATE_W'(S_RTYPEEX);
                    OP_BEQ:       state_d = STATE_W'(S_BEQEX);
                    OP_ADDI:      state_d = STATE_W'(S_ADDIEX);
                    OP_J:         state_d = STATE_W'(S_JEX);
                    default:      state_d = STATE_W'(S_FETCH);
                endcase
            end
            STATE_W'(S_MEMADR):  state_d = (bus.op == OP_SW) ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
            STATE_W'(S_MEMRD):   state_d = mem_ok ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMRD);
            STATE_W'(S_MEMWR):   state_d = mem_ok ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWR);
            STATE_W'(S_RTYPEEX): state_d = STATE_W'(S_RTYPEWB);
            STATE_W'(S_ADDIEX):  state_d = STATE_W'(S_ADDIWB);
            default:             state_d = STATE_W'(S_FETCH);
        endcase
    end

    // State register; reset overrides any pending transition.
    always_ff @(posedge clk) begin
        if (reset) state_q <= STATE_W'(S_FETCH);
        else       state_q <= state_d;
    end

    // While reset is held, every control output is forced low.
    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.pc_en      = ctrl_out.pc_en;
    assign bus.irwrite    = ctrl_out.irwrite;
    assign bus.memwrite   = ctrl_out.memwrite;
    assign bus.regwrite   = ctrl_out.regwrite;
    assign bus.iord       = ctrl_out.iord;
    assign bus.alusrca    = ctrl_out.alusrca;
    assign bus.alusrcb    = ctrl_out.alusrcb;
    assign bus.aluop      = ctrl_out.aluop;
    assign bus.pcsrc      = ctrl_out.pcsrc;
    assign bus.regdst     = ctrl_out.regdst;
    assign bus.memtoreg   = ctrl_out.memtoreg;
    assign bus.illegal_op = ctrl_out.illegal_op;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: each instruction is expanded into the
// cycle-by-cycle sequence of states and control words it must produce.
module tb_multicycle_control;
    import mips_pkg::*;

    typedef struct packed {
        state_t st;
        ctrl_t  c;
        logic   mr;
        logic   z;
    } step_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    step_t plan[$];

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4), .USE_MEM_READY(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t actual();
        ctrl_t a;
        a.pc_en      = bus.pc_en;
        a.irwrite    = bus.irwrite;
        a.memwrite   = bus.memwrite;
        a.regwrite   = bus.regwrite;
        a.iord       = bus.iord;
        a.alusrca    = bus.alusrca;
        a.alusrcb    = bus.alusrcb;
        a.aluop      = bus.aluop;
        a.pcsrc      = bus.pcsrc;
        a.regdst     = bus.regdst;
        a.memtoreg   = bus.memtoreg;
        a.illegal_op = bus.illegal_op;
        return a;
    endfunction

    // Control word required in a given state, straight from the state table.
    function automatic ctrl_t exp_ctrl(state_t s, logic [5:0] op, logic z, logic mr);
        ctrl_t c = '0;
        case (s)
            S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = mr; c.pc_en = mr; end
            S_DECODE:  begin c.alusrcb = 2'b11;
                             c.illegal_op = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                                         6'b000100, 6'b001000, 6'b000010}); end
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pc_en = z; end
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JEX:     begin c.pcsrc = 2'b10; c.pc_en = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic void push(state_t s, logic [5:0] op, logic mr, logic z);
        step_t t;
        t.st = s;
        t.mr = mr;
        t.z  = z;
        t.c  = exp_ctrl(s, op, z, mr);
        plan.push_back(t);
    endfunction

    // Expand one instruction into its expected cycle sequence.
    // fw/mw: cycles mem_ready is withheld in FETCH / in the memory access state.
    function automatic void plan_instr(logic [5:0] op, logic bz, int fw, int mw);
        plan.delete();
        for (int i = 0; i < fw; i++) push(S_FETCH, op, 1'b0, 1'($urandom));
        push(S_FETCH, op, 1'b1, 1'($urandom));
        push(S_DECODE, op, 1'($urandom), 1'($urandom));
        case (op)
            6'b100011: begin
                push(S_MEMADR, op, 1'($urandom), 1'($urandom));
                for (int i = 0; i < mw; i++) push(S_MEMRD, op, 1'b0, 1'($urandom));
                push(S_MEMRD, op, 1'b1, 1'($urandom));
                push(S_MEMWB, op, 1'($urandom), 1'($urandom));
            end
            6'b101011: begin
                push(S_MEMADR, op, 1'($urandom), 1'($urandom));
                for (int i = 0; i < mw; i++) push(S_MEMWR, op, 1'b0, 1'($urandom));
                push(S_MEMWR, op, 1'b1, 1'($urandom));
            end
            6'b000000: begin
                push(S_RTYPEEX, op, 1'($urandom), 1'($urandom));
                push(S_RTYPEWB, op, 1'($urandom), 1'($urandom));
            end
            6'b000100: push(S_BEQEX, op, 1'($urandom), bz);
            6'b001000: begin
                push(S_ADDIEX, op, 1'($urandom), 1'($urandom));
                push(S_ADDIWB, op, 1'($urandom), 1'($urandom));
            end
            6'b000010: push(S_JEX, op, 1'($urandom), 1'($urandom));
            default: ;
        endcase
    endfunction

    // Play the plan one cycle per step; optionally stop after checking the
    // first step in state stop_st (before its clock edge).
    task automatic run_plan(input string name, input logic [5:0] op, input int stop_st);
        ctrl_t a;
        bus.op = op;
        foreach (plan[i]) begin
            bus.mem_ready = plan[i].mr;
            bus.zero      = plan[i].z;
            @(negedge clk);
            a = actual();
            total++;
            if (bus.state_o !== plan[i].st) begin
                bad++;
                $display("FAIL %s state step %0d: got %0d want %0d", name, i, bus.state_o, plan[i].st);
            end
            total++;
            if (a !== plan[i].c) begin
                bad++;
                $display("FAIL %s ctrl step %0d: got %h want %h", name, i, a, plan[i].c);
            end
            total++;
            if ((a.regwrite && a.memwrite) ||
                (bus.state_o !== S_FETCH &&
                 $countones({a.pc_en, a.irwrite, a.regwrite, a.memwrite}) > 1)) begin
                bad++;
                $display("FAIL %s exclusive strobes step %0d: got %h want at most one", name, i, a);
            end
            if (int'(plan[i].st) == stop_st) return;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        bus.op = OP_J;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (actual() !== ctrl_t'(0)) begin
                bad++;
                $display("FAIL reset outputs cycle %0d: got %h want 0", k, actual());
            end
            total++;
            if (bus.state_o !== S_FETCH) begin
                bad++;
                $display("FAIL reset state cycle %0d: got %0d want %0d", k, bus.state_o, S_FETCH);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        plan_instr(OP_J, 1'b0, 0, 0);
        run_plan("reset_release_j", OP_J, -1);
    endtask

    task automatic test_lw();
        plan_instr(OP_LW, 1'b0, 0, 0);
        total++;
        if (plan.size() != 5) begin
            bad++;
            $display("FAIL lw latency plan: got %0d want 5", plan.size());
        end
        run_plan("lw", OP_LW, -1);
    endtask

    task automatic test_rtype_addi();
        plan_instr(OP_RTYPE, 1'b0, 0, 0);
        run_plan("rtype", OP_RTYPE, -1);
        plan_instr(OP_ADDI, 1'b0, 0, 0);
        run_plan("addi", OP_ADDI, -1);
    endtask

    task automatic test_beq();
        plan_instr(OP_BEQ, 1'b1, 0, 0);
        run_plan("beq_taken", OP_BEQ, -1);
        plan_instr(OP_BEQ, 1'b0, 0, 0);
        run_plan("beq_not_taken", OP_BEQ, -1);
    endtask

    task automatic test_mem_stall();
        plan_instr(OP_SW, 1'b0, 2, 3);
        run_plan("sw_stall", OP_SW, -1);
        plan_instr(OP_LW, 1'b0, 1, 2);
        run_plan("lw_stall", OP_LW, -1);
    endtask

    task automatic test_illegal();
        plan_instr(6'b111111, 1'b0, 0, 0);
        run_plan("illegal", 6'b111111, -1);
        plan_instr(OP_J, 1'b0, 0, 0);
        run_plan("after_illegal_j", OP_J, -1);
    endtask

    task automatic test_reset_mid();
        plan_instr(OP_LW, 1'b0, 0, 3);
        run_plan("lw_pre_reset", OP_LW, int'(S_MEMRD));
        reset = 1'b1;
        #1;
        total++;
        if (actual() !== ctrl_t'(0)) begin
            bad++;
            $display("FAIL reset_mid outputs: got %h want 0", actual());
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.state_o !== S_FETCH || actual() !== ctrl_t'(0)) begin
            bad++;
            $display("FAIL reset_mid after edge: state %0d ctrl %h want state %0d ctrl 0",
                     bus.state_o, actual(), S_FETCH);
        end
        reset = 1'b0;
        plan_instr(OP_ADDI, 1'b0, 0, 0);
        run_plan("after_reset_mid", OP_ADDI, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7];
        logic [5:0] op;
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
        ops[4] = OP_ADDI;  ops[5] = OP_J;  ops[6] = 6'b000000;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 6) == 0) op = 6'($urandom);
            plan_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            run_plan("random", op, -1);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_lw();
        test_rtype_addi();
        test_beq();
        test_mem_stall();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
